branch_trace_driver: RTL
========================

# branch_trace_driver

Trace replay stage that sits directly upstream of the perceptron branch predictor and also consumes its prediction. It buffers a trace of (ip, taken) branch records and replays them one per cycle, in the predictor's skewed protocol where each cycle carries a new ip plus the outcome of the previous branch. It scores each returned prediction against the true outcome and exposes correct and mispredict counters for the accuracy testbench and the FPGA harness.

## Interface
- DEPTH, 16, trace buffer entries (power of two, ≥2)
- CNT_W, 32, statistics counter width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_valid  in  1  trace record offered
- load_ready  out  1  record accepted this cycle when load_valid & load_ready
- load_ip  in  64  branch ip of record
- load_taken  in  1  actual outcome of record
- start  in  1  one-cycle pulse: begin replay (IDLE or DONE only)
- clear  in  1  one-cycle pulse: empty buffer, zero counters, go IDLE
- pred_ip  out  64  ip to predictor (registered)
- pred_taken  out  1  outcome of previously issued branch to predictor (registered)
- pred_valid  out  1  high while pred_ip/pred_taken carry live trace data
- pred_in  in  1  predictor output_prediction
- busy  out  1  state is RUN or FLUSH
- done  out  1  state is DONE
- total_cnt  out  CNT_W  branches scored
- correct_cnt  out  CNT_W  predictions equal to outcome
- miss_cnt  out  CNT_W  predictions differing from outcome

## Operation
- States: IDLE, RUN, FLUSH, DONE. Reset → IDLE.
- IDLE: load_ready = !full & !start & !clear. An accepted record is written at wr_ptr, and count increments. full = (count == DEPTH).
- IDLE + start: count == 0 → DONE with all counters 0. Otherwise → RUN, rd_ptr = 0, counters zeroed, issue index k = 0.
- RUN, cycle presenting entry k: pred_ip = ip[k], pred_taken = taken[k-1] (0 when k = 0), pred_valid = 1. When k = count-1, next state is FLUSH.
- FLUSH, one cycle: pred_ip = 0, pred_taken = taken[count-1], pred_valid = 1, then → DONE.
- Scoring: pred_in observed during the cycle after entry k is presented is the prediction for entry k. It is sampled at the end of that cycle and compared with taken[k]. total_cnt increments every scored entry. Match → correct_cnt+1, else miss_cnt+1. Scoring happens at the end of RUN cycles k ≥ 1 and at the end of FLUSH. No scoring in IDLE or DONE.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- DONE: outputs hold. Buffer contents are retained. start → RUN replays the same buffer with counters zeroed. load_ready = 0.
- clear, any state: next state IDLE, count/wr_ptr/rd_ptr/counters = 0. Takes priority over start and load.
- start in RUN or FLUSH: ignored.
- IDLE/DONE outputs: pred_ip = 0, pred_taken = 0, pred_valid = 0.

## Timing
- Reset values: load_ready 0 while reset_n low, then 1 in IDLE. pred_ip 0, pred_taken 0, pred_valid 0, busy 0, done 0, all counters 0, count 0.
- Reset mid-run: immediate abort to IDLE with buffer emptied. No partial statistics are retained.
- pred_* outputs are registered and change only on the rising clk edge. The predictor samples them at the following edge.
- Replay latency: start sampled at edge E0. Entry 0 is presented E0→E1. N entries take N RUN cycles plus 1 FLUSH cycle. done rises at edge E0+N+1.
- Final counter values are stable when done = 1. total_cnt = correct_cnt + miss_cnt = N (unsaturated).
- Buffer pointers are log2(DEPTH) bits and wrap. count is log2(DEPTH)+1 bits.
- pred_in is sampled only on the clock edge. No combinational path from pred_in to any output.

## Test plan
- Load 4 records (ip 0x10,0x20,0x30,0x40; taken 1,0,1,1) with pred_in tied 0, then start. Required: pred_ip sequence 0x10,0x20,0x30,0x40,0; pred_taken sequence 0,1,0,1,1. done rises 5 cycles after start. total 4, correct 1, miss 3.
- Same trace with pred_in tied 1 → correct 3, miss 1. Second start from DONE without reload → identical counts, counters zeroed at start.
- Fill DEPTH=16 records: load_ready drops after 16th acceptance. A 17th offer is not accepted. Replay → total 16.
- start with empty buffer → DONE next cycle, all counters 0, pred_valid never asserted.
- start and load_valid in the same IDLE cycle → load not accepted (load_ready 0), replay uses prior contents.
- reset_n low during RUN cycle 2 → all outputs 0 immediately, state IDLE, count 0. clear during FLUSH → IDLE, counters 0.
- Closed loop with the perceptron predictor, 64-record alternating-taken trace at one ip → miss_cnt at or below 8 after training.

Source files
------------

// File: rtl/branch_trace_if.sv
// Trace load port and skewed predictor port of the branch trace replay stage.
// master: trace source and predictor side; slave: branch_trace_driver.
interface branch_trace_if;
  logic        load_valid;
  logic        load_ready;
  logic [63:0] load_ip;
  logic        load_taken;
  logic [63:0] pred_ip;
  logic        pred_taken;
  logic        pred_valid;
  logic        pred_in;

  modport master (
    output load_valid, load_ip, load_taken, pred_in,
    input  load_ready, pred_ip, pred_taken, pred_valid
  );

  modport slave (
    input  load_valid, load_ip, load_taken, pred_in,
    output load_ready, pred_ip, pred_taken, pred_valid
  );
endinterface

// File: rtl/branch_trace_driver.sv
// Buffers (ip, taken) branch records and replays them to the perceptron predictor
// in its skewed protocol, scoring each returned prediction against the true outcome.
module branch_trace_driver #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  branch_trace_if.slave      bus,
  input  logic               start,
  input  logic               clear,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   total_cnt,
  output logic [CNT_W-1:0]   correct_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [63:0]       pred_ip_q, pred_ip_d;
  logic              pred_taken_q, pred_taken_d;
  logic              pred_valid_q, pred_valid_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  correct_q, correct_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic [63:0]       ip_mem [DEPTH];
  logic [DEPTH-1:0]  taken_mem;
  logic              wr_en;
  logic              score;
  logic              ready;
  logic [AW-1:0]     nxt_ptr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pred_ip_d    = pred_ip_q;
    pred_taken_d = pred_taken_q;
    pred_valid_d = pred_valid_q;
    total_d      = total_q;
    correct_d    = correct_q;
    miss_d       = miss_q;
    wr_en        = 1'b0;
    score        = 1'b0;
    ready        = 1'b0;
    nxt_ptr      = rd_ptr_q + AW'(1);

    unique case (state_q)
      S_IDLE: begin
        ready = reset_n & (count_q != CW'(DEPTH)) & ~start & ~clear;
        if (bus.load_valid && ready) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
        end
      end
      S_RUN: begin
        // Entry 0's prediction only arrives in the following cycle.
        score = (rd_ptr_q != '0);
        if ({1'b0, rd_ptr_q} == count_q - CW'(1)) begin
          state_d      = S_FLUSH;
          pred_ip_d    = '0;
          pred_taken_d = taken_mem[rd_ptr_q];
        end else begin
          rd_ptr_d     = nxt_ptr;
          pred_ip_d    = ip_mem[nxt_ptr];
          pred_taken_d = taken_mem[rd_ptr_q];
        end
      end
      S_FLUSH: begin
        score        = 1'b1;
        state_d      = S_DONE;
        pred_ip_d    = '0;
        pred_taken_d = 1'b0;
        pred_valid_d = 1'b0;
      end
      default: ;
    endcase

    if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      total_d      = '0;
      correct_d    = '0;
      miss_d       = '0;
      rd_ptr_d     = '0;
      pred_taken_d = 1'b0;
      if (count_q == '0) begin
        state_d      = S_DONE;
        pred_ip_d    = '0;
        pred_valid_d = 1'b0;
      end else begin
        state_d      = S_RUN;
        pred_ip_d    = ip_mem[0];
        pred_valid_d = 1'b1;
      end
    end

    // pred_taken_q holds the true outcome of the entry being scored.
    if (score) begin
      total_d = sat_inc(total_q);
      if (bus.pred_in == pred_taken_q) correct_d = sat_inc(correct_q);
      else                             miss_d    = sat_inc(miss_q);
    end

    if (clear) begin
      state_d      = S_IDLE;
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      pred_ip_d    = '0;
      pred_taken_d = 1'b0;
      pred_valid_d = 1'b0;
      total_d      = '0;
      correct_d    = '0;
      miss_d       = '0;
      wr_en        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pred_ip_q    <= '0;
      pred_taken_q <= 1'b0;
      pred_valid_q <= 1'b0;
      total_q      <= '0;
      correct_q    <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pred_ip_q    <= pred_ip_d;
      pred_taken_q <= pred_taken_d;
      pred_valid_q <= pred_valid_d;
      total_q      <= total_d;
      correct_q    <= correct_d;
      miss_q       <= miss_d;
    end
  end

  // Trace storage carries no reset; count gates what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ip_mem[wr_ptr_q]    <= bus.load_ip;
      taken_mem[wr_ptr_q] <= bus.load_taken;
    end
  end

  assign bus.load_ready = ready;
  assign bus.pred_ip    = pred_ip_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.pred_valid = pred_valid_q;
  assign busy           = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done           = (state_q == S_DONE);
  assign total_cnt      = total_q;
  assign correct_cnt    = correct_q;
  assign miss_cnt       = miss_q;

endmodule
